// File: rtl/sr_excite_gen.sv
// sr_excite_gen: drives minimal S/R excitation into an srff for each accepted
// target bit, then reads the flop back after a settle window and records
// mismatches in a sticky flag and a saturating counter.
module sr_excite_gen #(
    parameter int unsigned PULSE_CYC  = 1,
    parameter int unsigned SETTLE_CYC = 1,
    parameter logic        RST_Q      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic       tgt_bit,
    output logic       tgt_ready,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    input  logic       clear_err,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam int unsigned MAX_CYC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exp_q, exp_d;
    logic          shadow_q, shadow_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          tgt_ready_q, tgt_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    // Next-state and registered-output computation for the drive/check sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        shadow_d    = shadow_q;
        s_d         = s_q;
        r_d         = r_q;
        tgt_ready_d = tgt_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (clear_err) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (tgt_valid && tgt_ready_q) begin
                    exp_d       = tgt_bit;
                    cnt_d       = '0;
                    tgt_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (tgt_bit != shadow_q) begin
                        state_d = DRIVE;
                        s_d     = tgt_bit;
                        r_d     = ~tgt_bit;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d  = CHECK;
                    cnt_d    = '0;
                    s_d      = 1'b0;
                    r_d      = 1'b0;
                    shadow_d = exp_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CHECK: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d     = IDLE;
                    tgt_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    shadow_d    = exp_q;
                    // A mismatch on the same edge as clear_err overrides the clear.
                    if (q_fb != exp_q) begin
                        err_d = 1'b1;
                        if (clear_err) begin
                            err_cnt_d = 8'd1;
                        end else if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            exp_q       <= 1'b0;
            shadow_q    <= RST_Q;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            tgt_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            shadow_q    <= shadow_d;
            s_q         <= s_d;
            r_q         <= r_d;
            tgt_ready_q <= tgt_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign tgt_ready = tgt_ready_q;
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sr_excite_gen.sv
// Bench for sr_excite_gen: channel 0 uses default timing with an srff model
// (readback optionally forced to 1), channel 1 uses PULSE_CYC=3, SETTLE_CYC=2.
module tb_sr_excite_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tgt_valid;
    logic [1:0] tgt_bit;
    logic       clear_err;
    logic       fb_tie;
    logic [1:0] ff_q;

    wire [1:0] tgt_ready;
    wire [1:0] s;
    wire [1:0] r;
    wire [1:0] busy;
    wire [1:0] done;
    wire [1:0] err;
    wire [7:0] err_cnt0;
    wire [7:0] err_cnt1;
    wire [1:0] q_fb;

    always #5 clk = ~clk;

    assign q_fb = {ff_q[1], ff_q[0] | fb_tie};

    sr_excite_gen u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid[0]),
        .tgt_bit   (tgt_bit[0]),
        .tgt_ready (tgt_ready[0]),
        .s         (s[0]),
        .r         (r[0]),
        .q_fb      (q_fb[0]),
        .clear_err (clear_err),
        .busy      (busy[0]),
        .done      (done[0]),
        .err       (err[0]),
        .err_cnt   (err_cnt0)
    );

    sr_excite_gen #(
        .PULSE_CYC  (3),
        .SETTLE_CYC (2),
        .RST_Q      (1'b1)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid[1]),
        .tgt_bit   (tgt_bit[1]),
        .tgt_ready (tgt_ready[1]),
        .s         (s[1]),
        .r         (r[1]),
        .q_fb      (q_fb[1]),
        .clear_err (1'b0),
        .busy      (busy[1]),
        .done      (done[1]),
        .err       (err[1]),
        .err_cnt   (err_cnt1)
    );

    // srff models (reset value 1) for both channels.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s[i]) ff_q[i] <= 1'b1;
                else if (r[i]) ff_q[i] <= 1'b0;
            end
        end
    end

    typedef struct {
        int   lat;
        int   sc;
        int   rc;
        logic err;
        int   cnt;
        logic q;
    } exp_t;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [13:0] snapq[$];
    string       snapnm[$];

    int vectors     = 0;
    int miscompares = 0;
    int mon_act[2]  = '{0, 0};
    int mon_lat[2]  = '{0, 0};
    int mon_s[2]    = '{0, 0};
    int mon_r[2]    = '{0, 0};

    localparam logic [13:0] IDLE_OK = {6'b100000, 8'd0};

    // Monitor: measures each transaction and checks it against the scoreboard.
    always @(negedge clk) begin
        exp_t        e;
        logic        have;
        logic [7:0]  cg;
        logic [13:0] act_v;
        logic [13:0] req_v;
        string       nm;
        for (int g = 0; g < 2; g++) begin
            cg = (g == 0) ? err_cnt0 : err_cnt1;
            if (rst) begin
                mon_act[g] = 0;
            end else begin
                if (mon_act[g] != 0) begin
                    mon_lat[g]++;
                    mon_s[g] += int'(s[g]);
                    mon_r[g] += int'(r[g]);
                end
                if (s[g] && r[g]) begin
                    miscompares++;
                    $display("FAIL excl ch%0d: s=1 r=1, required never both high", g);
                end
                if (done[g]) begin
                    vectors++;
                    have = (g == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
                    if (mon_act[g] == 0 || !have) begin
                        miscompares++;
                        $display("FAIL done_unexpected ch%0d: done=1 with no pending transaction, required 0", g);
                    end else begin
                        if (g == 0) e = sb0.pop_front();
                        else        e = sb1.pop_front();
                        if (mon_lat[g] != e.lat || mon_s[g] != e.sc || mon_r[g] != e.rc ||
                            err[g] !== e.err || int'(cg) != e.cnt || ff_q[g] !== e.q) begin
                            miscompares++;
                            $display("FAIL txn ch%0d: got lat=%0d s_cyc=%0d r_cyc=%0d err=%b cnt=%0d q=%b, required lat=%0d s_cyc=%0d r_cyc=%0d err=%b cnt=%0d q=%b",
                                     g, mon_lat[g], mon_s[g], mon_r[g], err[g], cg, ff_q[g],
                                     e.lat, e.sc, e.rc, e.err, e.cnt, e.q);
                        end
                    end
                    mon_act[g] = 0;
                end
                if (tgt_valid[g] && tgt_ready[g]) begin
                    mon_act[g] = 1;
                    mon_lat[g] = 0;
                    mon_s[g]   = 0;
                    mon_r[g]   = 0;
                end
            end
        end
        if (snapq.size() > 0) begin
            req_v = snapq.pop_front();
            nm    = snapnm.pop_front();
            act_v = {tgt_ready[0], busy[0], done[0], s[0], r[0], err[0], err_cnt0};
            vectors++;
            if (act_v !== req_v) begin
                miscompares++;
                $display("FAIL %s: {rdy,busy,done,s,r,err,cnt}=%h, required %h", nm, act_v, req_v);
            end
        end
    end

    function automatic exp_t mk(int lat, int sc, int rc, logic e, int cnt, logic q);
        exp_t x;
        x.lat = lat; x.sc = sc; x.rc = rc; x.err = e; x.cnt = cnt; x.q = q;
        return x;
    endfunction

    task automatic send(input int idx, input logic b, input exp_t e, input bit track);
        int n;
        n = 0;
        if (track) begin
            if (idx == 0) sb0.push_back(e);
            else          sb1.push_back(e);
        end
        tgt_bit[idx]   = b;
        tgt_valid[idx] = 1'b1;
        @(negedge clk);
        while (!tgt_ready[idx]) begin
            n++;
            if (n > 100) begin
                $display("FAIL hs_timeout ch%0d: tgt_ready=0 for %0d cycles, required 1", idx, n);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        tgt_valid[idx] = 1'b0;
    endtask

    task automatic snap(input logic [13:0] v, input string nm);
        snapq.push_back(v);
        snapnm.push_back(nm);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb0.size() > 0 || sb1.size() > 0 || snapq.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL drain_timeout: %0d/%0d/%0d entries still pending, required 0",
                         sb0.size(), sb1.size(), snapq.size());
                $fatal(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        tgt_valid = '0;
        tgt_bit   = '0;
        clear_err = 1'b0;
        fb_tie    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        snap(IDLE_OK, "reset_state");
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        snap(IDLE_OK, "after_reset");

        // Hold: target equals reset value.
        send(0, 1'b1, mk(2, 0, 0, 1'b0, 0, 1'b1), 1'b1);
        drain();

        // Back-to-back reset then set.
        send(0, 1'b0, mk(3, 0, 1, 1'b0, 0, 1'b0), 1'b1);
        send(0, 1'b1, mk(3, 1, 0, 1'b0, 0, 1'b1), 1'b1);
        drain();

        // Readback stuck at 1: every target 0 mismatches; counter saturates.
        fb_tie = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            send(0, 1'b0, mk((i == 1) ? 3 : 2, 0, (i == 1) ? 1 : 0, 1'b1,
                             (i < 255) ? i : 255, 1'b0), 1'b1);
        end
        drain();

        // clear_err on the mismatch edge: mismatch wins.
        send(0, 1'b0, mk(2, 0, 0, 1'b1, 1, 1'b0), 1'b1);
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        drain();
        snap({6'b100001, 8'd1}, "err_kept");
        drain();
        clear_err = 1'b1;
        @(posedge clk);
        #1;
        clear_err = 1'b0;
        snap(IDLE_OK, "err_cleared");
        drain();

        // Set back to 1 with true readback, then reset in the middle of DRIVE.
        fb_tie = 1'b0;
        send(0, 1'b1, mk(3, 1, 0, 1'b0, 0, 1'b1), 1'b1);
        drain();
        send(0, 1'b0, mk(0, 0, 0, 1'b0, 0, 1'b0), 1'b0);
        #1;
        rst = 1'b1;
        snap(IDLE_OK, "rst_in_drive");
        @(negedge clk);
        #1;
        rst = 1'b0;
        drain();
        send(0, 1'b1, mk(2, 0, 0, 1'b0, 0, 1'b1), 1'b1);
        drain();

        // Long pulse / long settle channel.
        send(1, 1'b0, mk(6, 0, 3, 1'b0, 0, 1'b0), 1'b1);
        send(1, 1'b1, mk(6, 3, 0, 1'b0, 0, 1'b1), 1'b1);
        send(1, 1'b1, mk(3, 0, 0, 1'b0, 0, 1'b1), 1'b1);
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
